// File: rtl/switch_led_pkg.sv
// Shared types and constants for the switch/LED mode controller.
// Mode encodings, switch count and speed width, plus the mode-advance helper.
`timescale 1ns/1ps
package switch_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_MANUAL = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_CHASE  = 2'b11
  } mode_e;

  localparam int NUM_SWITCHES = 4;
  localparam int SPEED_W      = 2;

  // OFF -> MANUAL -> BLINK -> CHASE -> OFF
  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    unique case (m)
      MODE_OFF:    r = MODE_MANUAL;
      MODE_MANUAL: r = MODE_BLINK;
      MODE_BLINK:  r = MODE_CHASE;
      MODE_CHASE:  r = MODE_OFF;
      default:     r = MODE_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/switch_led_controller_debounce.sv
// switch_debounce: 2-flop synchronizer, debounce counter, release pulse.
// Ports: i_Clk, i_Rst (async high), i_Switch (raw), o_Release (1-cycle).
`timescale 1ns/1ps
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Release
);

  localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ?
    $clog2(DEBOUNCE_LIMIT) : 1;

  logic             sync_0;
  logic             sync_1;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] count;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_0    <= 1'b0;
      sync_1    <= 1'b0;
      stable    <= 1'b0;
      stable_d  <= 1'b0;
      count     <= '0;
      o_Release <= 1'b0;
    end else begin
      sync_0 <= i_Switch;
      sync_1 <= sync_0;
      // Count consecutive disagreeing edges; any agreement restarts.
      if (sync_1 == stable) begin
        count <= '0;
      end else if (count == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
        stable <= sync_1;
        count  <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
      stable_d  <= stable;
      // Falling stable level only; presses produce nothing.
      o_Release <= stable_d & ~stable;
    end
  end

endmodule

// File: rtl/switch_led_controller.sv
// Four-switch LED sequencer: OFF/MANUAL/BLINK/CHASE modes, variable speed.
// Ports: i_Clk, i_Rst (async high), i_Switch_1..4 raw, o_LED_1..4, o_Mode.
// Option SWITCH_LED_CURSOR_BLINK_EN: blink the cursor LED in MANUAL.
`timescale 1ns/1ps
module switch_led_controller
  import switch_led_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int TICK_LIMIT     = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
);

  localparam int TICK_W = $clog2(TICK_LIMIT + 1);

  logic [NUM_SWITCHES-1:0] raw;
  logic [NUM_SWITCHES-1:0] rel;

  assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_db
    switch_debounce #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_db (
      .i_Clk    (i_Clk),
      .i_Rst    (i_Rst),
      .i_Switch (raw[g]),
      .o_Release(rel[g])
    );
  end

  logic ev_mode;
  logic ev_speed;
  logic ev_toggle;
  logic ev_cursor;

  assign ev_mode   = rel[0];
  assign ev_speed  = rel[1];
  assign ev_toggle = rel[2];
  assign ev_cursor = rel[3];

  mode_e              mode;
  logic [SPEED_W-1:0] speed;
  logic [3:0]         man;
  logic [1:0]         cursor;
  logic [1:0]         pos;
  logic               phase;

  logic [TICK_W-1:0]  tick_cnt;
  logic [TICK_W-1:0]  period;
  logic               change;
  logic               terminal;
  logic               tick;

  assign period   = TICK_W'(TICK_LIMIT >> speed);
  assign change   = ev_mode | ev_speed;
  assign terminal = (tick_cnt == period - TICK_W'(1));
  // A mode/speed change restarts the period, so it swallows the tick.
  assign tick     = terminal & ~change;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      tick_cnt <= '0;
    end else if (change || terminal) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mode   <= MODE_OFF;
      speed  <= '0;
      man    <= '0;
      cursor <= '0;
      pos    <= '0;
      phase  <= 1'b0;
    end else begin
      if (ev_speed) begin
        speed <= speed + SPEED_W'(1);
      end
      // Toggle uses the cursor value from before this edge.
      if (mode == MODE_MANUAL) begin
        if (ev_toggle) begin
          man[cursor] <= ~man[cursor];
        end
        if (ev_cursor) begin
          cursor <= cursor + 2'd1;
        end
      end
      if (ev_mode) begin
        mode <= next_mode(mode);
        unique case (next_mode(mode))
          MODE_BLINK:  phase <= 1'b1;
          MODE_CHASE:  pos   <= 2'd0;
`ifdef SWITCH_LED_CURSOR_BLINK_EN
          MODE_MANUAL: phase <= 1'b1;
`endif
          default: ;
        endcase
      end else if (tick) begin
        unique case (mode)
          MODE_BLINK:  phase <= ~phase;
          MODE_CHASE:  pos   <= pos + 2'd1;
`ifdef SWITCH_LED_CURSOR_BLINK_EN
          MODE_MANUAL: phase <= ~phase;
`endif
          default: ;
        endcase
      end
    end
  end

  logic [3:0] led_next;
  logic [3:0] leds;

  always_comb begin
    led_next = '0;
    unique case (mode)
      MODE_OFF: led_next = '0;
      MODE_MANUAL: begin
        led_next = man;
`ifdef SWITCH_LED_CURSOR_BLINK_EN
        led_next[cursor] = man[cursor] ^ phase;
`endif
      end
      MODE_BLINK: led_next = {4{phase}};
      MODE_CHASE: led_next = 4'b0001 << pos;
      default:    led_next = '0;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      leds   <= '0;
      o_Mode <= MODE_OFF;
    end else begin
      leds   <= led_next;
      o_Mode <= mode;
    end
  end

  assign o_LED_1 = leds[0];
  assign o_LED_2 = leds[1];
  assign o_LED_3 = leds[2];
  assign o_LED_4 = leds[3];

endmodule

// File: doc/switch_led_controller.md
Name: switch_led_controller

Overview:
- Sequences the four board LEDs from four push-button switches.
- Each switch is synchronized and debounced, and its release (falling edge) becomes a one-cycle event.
- The events drive a mode state machine: OFF, MANUAL, BLINK, CHASE.
- Sits between the raw switch pins and LED pins at top level; replaces ad-hoc per-switch toggle logic.

Parameters:
- DEBOUNCE_LIMIT, 250000, consecutive clocks a synchronized switch level must differ before it is accepted (10 ms at 25 MHz).
- TICK_LIMIT, 6250000, base animation period in clocks (250 ms at 25 MHz). Must be ≥ 8.

Ports:
- i_Clk  input  1  25 MHz system clock.
- i_Rst  input  1  asynchronous, active-high reset.
- i_Switch_1  input  1  raw switch; release = next mode.
- i_Switch_2  input  1  raw switch; release = next speed.
- i_Switch_3  input  1  raw switch; release = toggle manual bit at cursor.
- i_Switch_4  input  1  raw switch; release = advance cursor.
- o_LED_1..o_LED_4  output  1 each  LED drives, registered.
- o_Mode  output  2  current mode, registered (debug).

Behaviour:
- Reset (async, i_Rst=1): all state cleared immediately.
  - mode=OFF(00), speed=0, manual m[3:0]=0, cursor=0, chase pos=0, blink phase=0.
  - Tick counter and debouncer counters=0; debounced levels=0.
  - All LEDs=0, o_Mode=00.
  - Reset mid-press: the press is lost; the debouncer restarts from level 0.
- Input sync: 2-flop synchronizer per switch (2 edges).
- Debounce: counter increments each edge while the synchronized level differs from the stable level, and clears when they match.
  - On the DEBOUNCE_LIMIT-th consecutive differing edge, stable takes the synchronized value and the counter clears.
  - Glitches shorter than DEBOUNCE_LIMIT clocks are ignored.
- Release event: registered one-cycle pulse, asserted the edge after stable goes 1→0. Presses (0→1) generate nothing.
- Latency, raw switch fall to LED change: DEBOUNCE_LIMIT+5 edges.
  - sync 2, debounce DEBOUNCE_LIMIT, pulse 1, state 1, LED register 1.
- Mode FSM (SW1 event): OFF→MANUAL→BLINK→CHASE→OFF.
  - Entering BLINK sets phase=1.
  - Entering CHASE sets pos=0.
- Speed (SW2 event): speed=speed+1, 2-bit, wraps 3→0. Accepted in every mode.
- Tick period: TICK_LIMIT>>speed clocks.
  - Counter runs 0..period-1 and emits a one-cycle tick on the terminal count.
  - Counter clears on any mode or speed change.
- Outputs by mode:
  - OFF: LEDs=0000.
  - MANUAL: LEDs={LED4..LED1}=m[3:0].
    - SW4 event: cursor+1, wraps 3→0.
    - SW3 event: m[cursor]^=1.
  - BLINK: all LEDs=phase; phase toggles each tick.
  - CHASE: LED[pos+1]=1, others 0; pos+1 each tick, wraps 3→0.
- SW3/SW4 events outside MANUAL are ignored. m and cursor persist across mode changes.
- Simultaneous events in one cycle:
  - All are applied, each evaluated against pre-update state.
  - SW3+SW4: toggle uses the old cursor, then the cursor advances.
  - SW1+SW3 in MANUAL: toggle applied and mode advances.
  - SW1+SW2: both applied, counter cleared once.

Optional Feature:
- Macro: SWITCH_LED_CURSOR_BLINK_EN.
- Defined: in MANUAL, the LED at cursor shows m[cursor]^phase.
  - phase toggles every tick as in BLINK, and is set to 1 on entering MANUAL.
  - Makes the cursor visible.
- Undefined: MANUAL LEDs equal m exactly, and no tick logic is consulted in MANUAL.

Decomposition:
- Package switch_led_pkg:
  - mode encodings MODE_OFF=2'b00, MODE_MANUAL=2'b01, MODE_BLINK=2'b10, MODE_CHASE=2'b11.
  - NUM_SWITCHES=4, SPEED_W=2.
- Sub-module switch_debounce: synchronizer + debounce counter + release-pulse register, parameterized by DEBOUNCE_LIMIT. Instantiated 4×.
- FSM, tick generator and LED mux stay in the top.

Test Plan (DEBOUNCE_LIMIT=4, TICK_LIMIT=16, macro undefined unless stated):
- Reset: assert i_Rst mid-run → LEDs=0000 and o_Mode=00 asynchronously, before the next edge; hold 3 clocks, release → still 0000/00.
- Bounce: SW1 high 3 clocks then low → no mode change. SW1 high 10 clocks, then low → o_Mode=01 exactly 9 edges after the fall.
- Manual: in MANUAL, SW4 release once, then SW3 release → LEDs 0010 (LED2 lit). SW3 again → 0000. SW3+SW4 released together from cursor=1 → LED2 on, cursor=2.
- Blink/speed: enter BLINK → LEDs 1111 for 16 clocks, then 0000 for 16. SW2 release → period 8. Three more SW2 releases → period back to 16.
- Chase: enter CHASE → LEDs 0001, 0010, 0100, 1000, 0001, stepping every 16 clocks. SW1 release → OFF, LEDs 0000. m preserved on return to MANUAL.
- Option: with SWITCH_LED_CURSOR_BLINK_EN, MANUAL m=0000, cursor=0 → LED1 alternates 1/0 every 16 clocks, LED2–4 stay 0.
